// File: rtl/fpnew_pkg.sv
// Shared FPU types: IEEE status flags, result-merger retire modes and index-width helper.
package fpnew_pkg;

  typedef struct packed {
    logic NV;
    logic DZ;
    logic OF;
    logic UF;
    logic NX;
  } status_t;

  typedef enum logic {
    RR_RETIRE      = 1'b0,
    INORDER_RETIRE = 1'b1
  } merger_mode_e;

  // Index width that stays at least one bit even for a single entry.
  function automatic int unsigned lane_idx_width(input int unsigned n);
    return (n > 32'd1) ? int'($clog2(n)) : 32'd1;
  endfunction

endpackage

// File: rtl/fpnew_opgroup_result_merger_chk.sv
// Protocol checks for the result merger: legal issue lanes and stable stalled outputs.
module fpnew_opgroup_result_merger_chk #(
  parameter int unsigned NumLanes = 5,
  parameter int unsigned LaneIdxW = 3,
  parameter int unsigned Width    = 64,
  parameter bit          InOrder  = 1'b0
) (
  input logic                clk_i,
  input logic                rst_ni,
  input logic                flush_i,
  input logic                issue_valid_i,
  input logic [LaneIdxW-1:0] issue_lane_i,
  input logic                out_valid,
  input logic                out_ready,
  input logic [Width-1:0]    result,
  input logic [LaneIdxW-1:0] out_lane
);

  a_issue_lane_legal: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (InOrder && issue_valid_i) |-> ({1'b0, issue_lane_i} < (LaneIdxW+1)'(NumLanes)));

  a_stall_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (out_valid && !out_ready && !flush_i) |=>
      (out_valid && $stable(result) && $stable(out_lane)));

endmodule

// File: rtl/fpnew_result_fifo.sv
// Small circular FIFO with synchronous flush; a push into a full FIFO is accepted only
// when the same cycle pops.
module fpnew_result_fifo
  import fpnew_pkg::*;
#(
  parameter type         DataType = logic,
  parameter int unsigned Depth    = 2
) (
  input  logic    clk_i,
  input  logic    rst_ni,
  input  logic    flush_i,
  input  logic    push_i,
  input  DataType data_i,
  input  logic    pop_i,
  output DataType data_o,
  output logic    full_o,
  output logic    empty_o
);

  localparam int unsigned PtrW = lane_idx_width(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  DataType         mem_r [Depth];
  logic [PtrW-1:0] wptr_r, rptr_r;
  logic [CntW-1:0] cnt_r;
  logic            do_push_s, do_pop_s;

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? {PtrW{1'b0}} : p + PtrW'(1);
  endfunction

  assign full_o    = (cnt_r == CntW'(Depth));
  assign empty_o   = (cnt_r == {CntW{1'b0}});
  assign do_pop_s  = pop_i && !empty_o;
  assign do_push_s = push_i && (!full_o || do_pop_s);
  assign data_o    = mem_r[rptr_r];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_r <= {PtrW{1'b0}};
      rptr_r <= {PtrW{1'b0}};
      cnt_r  <= {CntW{1'b0}};
    end else if (flush_i) begin
      wptr_r <= {PtrW{1'b0}};
      rptr_r <= {PtrW{1'b0}};
      cnt_r  <= {CntW{1'b0}};
    end else begin
      if (do_push_s) wptr_r <= next_ptr(wptr_r);
      if (do_pop_s)  rptr_r <= next_ptr(rptr_r);
      case ({do_push_s, do_pop_s})
        2'b10:   cnt_r <= cnt_r + CntW'(1);
        2'b01:   cnt_r <= cnt_r - CntW'(1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // Payload storage; contents are don't-care while the slot is empty.
  always_ff @(posedge clk_i) begin
    if (do_push_s && !flush_i) mem_r[wptr_r] <= data_i;
  end

endmodule

// File: rtl/fpnew_opgroup_result_merger.sv
// Merges per-slice FP results into one stream, retiring round-robin or in issue order.
module fpnew_opgroup_result_merger
  import fpnew_pkg::*;
#(
  parameter int unsigned NumLanes   = 5,
  parameter int unsigned Width      = 64,
  parameter int unsigned FifoDepth  = 2,
  parameter bit          InOrder    = 1'b0,
  parameter int unsigned OrderDepth = 8,
  parameter type         TagType    = logic,
  localparam int unsigned LaneIdxW  = lane_idx_width(NumLanes)
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [NumLanes-1:0]                lane_valid_i,
  output logic [NumLanes-1:0]                lane_ready_o,
  input  logic [NumLanes-1:0][Width-1:0]     lane_result_i,
  input  status_t [NumLanes-1:0]             lane_status_i,
  input  logic [NumLanes-1:0]                lane_ext_bit_i,
  input  TagType [NumLanes-1:0]              lane_tag_i,
  input  logic                               issue_valid_i,
  input  logic [LaneIdxW-1:0]                issue_lane_i,
  output logic                               issue_ready_o,
  input  logic                               flush_i,
  output logic                               out_valid_o,
  input  logic                               out_ready_i,
  output logic [Width-1:0]                   result_o,
  output status_t                            status_o,
  output logic                               extension_bit_o,
  output TagType                             tag_o,
  output logic [LaneIdxW-1:0]                out_lane_o,
  output logic                               busy_o
);

  localparam merger_mode_e Mode = InOrder ? INORDER_RETIRE : RR_RETIRE;

  typedef struct packed {
    logic [Width-1:0] result;
    status_t          status;
    logic             ext_bit;
    TagType           tag;
  } lane_entry_t;

  lane_entry_t         lane_head_s [NumLanes];
  lane_entry_t         sel_entry_s;
  logic [NumLanes-1:0] lane_full_s, lane_empty_s, lane_pop_s;
  logic                order_empty_s, order_full_s;
  logic [LaneIdxW-1:0] order_head_s;
  logic [LaneIdxW-1:0] rr_ptr_r, lock_lane_r, rr_lane_s, grant_s;
  logic                lock_r, out_valid_s, hs_s;

  for (genvar i = 0; i < NumLanes; i++) begin : g_lane
    lane_entry_t din_s;
    assign din_s.result  = lane_result_i[i];
    assign din_s.status  = lane_status_i[i];
    assign din_s.ext_bit = lane_ext_bit_i[i];
    assign din_s.tag     = lane_tag_i[i];
    assign lane_pop_s[i] = hs_s && (grant_s == LaneIdxW'(i));

    fpnew_result_fifo #(.DataType(lane_entry_t), .Depth(FifoDepth)) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .flush_i (flush_i),
      .push_i  (lane_valid_i[i] && !lane_full_s[i]),
      .data_i  (din_s),
      .pop_i   (lane_pop_s[i]),
      .data_o  (lane_head_s[i]),
      .full_o  (lane_full_s[i]),
      .empty_o (lane_empty_s[i])
    );
  end

  if (Mode == INORDER_RETIRE) begin : g_order
    // A full order FIFO still takes an issue in a cycle that retires its head.
    assign issue_ready_o = !order_full_s || hs_s;

    fpnew_result_fifo #(.DataType(logic [LaneIdxW-1:0]), .Depth(OrderDepth)) u_order_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .flush_i (flush_i),
      .push_i  (issue_valid_i && issue_ready_o),
      .data_i  (issue_lane_i),
      .pop_i   (hs_s),
      .data_o  (order_head_s),
      .full_o  (order_full_s),
      .empty_o (order_empty_s)
    );
  end else begin : g_no_order
    assign issue_ready_o = 1'b1;
    assign order_head_s  = {LaneIdxW{1'b0}};
    assign order_full_s  = 1'b0;
    assign order_empty_s = 1'b1;
  end

  // Round-robin pick: first non-empty lane at or after the pointer, with wrap-around.
  always_comb begin
    logic [LaneIdxW:0] sum;
    logic              hit;
    logic              found;
    sum       = {(LaneIdxW+1){1'b0}};
    hit       = 1'b0;
    found     = 1'b0;
    rr_lane_s = {LaneIdxW{1'b0}};
    for (int k = 0; k < int'(NumLanes); k++) begin
      sum       = {1'b0, rr_ptr_r} + (LaneIdxW+1)'(k);
      sum       = (sum >= (LaneIdxW+1)'(NumLanes)) ? sum - (LaneIdxW+1)'(NumLanes) : sum;
      hit       = !found && !lane_empty_s[sum[LaneIdxW-1:0]];
      rr_lane_s = hit ? sum[LaneIdxW-1:0] : rr_lane_s;
      found     = found | hit;
    end
  end

  // Grant and valid; a stalled round-robin grant stays locked until it retires.
  always_comb begin
    grant_s     = {LaneIdxW{1'b0}};
    out_valid_s = 1'b0;
    if (Mode == INORDER_RETIRE) begin
      grant_s     = order_head_s;
      out_valid_s = !order_empty_s && ({1'b0, order_head_s} < (LaneIdxW+1)'(NumLanes)) &&
                    !lane_empty_s[order_head_s];
    end else begin
      grant_s     = lock_r ? lock_lane_r : rr_lane_s;
      out_valid_s = !(&lane_empty_s);
    end
  end

  // Round-robin pointer and stall lock.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_r    <= {LaneIdxW{1'b0}};
      lock_r      <= 1'b0;
      lock_lane_r <= {LaneIdxW{1'b0}};
    end else if (flush_i) begin
      rr_ptr_r    <= {LaneIdxW{1'b0}};
      lock_r      <= 1'b0;
      lock_lane_r <= {LaneIdxW{1'b0}};
    end else begin
      lock_r      <= out_valid_s && !out_ready_i;
      lock_lane_r <= grant_s;
      if (hs_s) begin
        rr_ptr_r <= (grant_s == LaneIdxW'(NumLanes - 1)) ? {LaneIdxW{1'b0}} : grant_s + LaneIdxW'(1);
      end
    end
  end

  assign hs_s            = out_valid_s && out_ready_i;
  assign sel_entry_s     = lane_head_s[grant_s];
  assign lane_ready_o    = ~lane_full_s;
  assign out_valid_o     = out_valid_s;
  assign result_o        = sel_entry_s.result;
  assign status_o        = sel_entry_s.status;
  assign extension_bit_o = sel_entry_s.ext_bit;
  assign tag_o           = sel_entry_s.tag;
  assign out_lane_o      = grant_s;
  assign busy_o          = !(&lane_empty_s) || ((Mode == INORDER_RETIRE) && !order_empty_s);

  fpnew_opgroup_result_merger_chk #(
    .NumLanes(NumLanes), .LaneIdxW(LaneIdxW), .Width(Width), .InOrder(InOrder)
  ) u_chk (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .flush_i       (flush_i),
    .issue_valid_i (issue_valid_i),
    .issue_lane_i  (issue_lane_i),
    .out_valid     (out_valid_s),
    .out_ready     (out_ready_i),
    .result        (result_o),
    .out_lane      (out_lane_o)
  );

endmodule

// File: tb/tb_fpnew_opgroup_result_merger.sv
// Scoreboard bench: a round-robin and an in-order merger checked against per-lane queue models.
module tb_fpnew_opgroup_result_merger;
  import fpnew_pkg::*;

  localparam int NL = 5;
  localparam int FD = 2;
  localparam int OD = 8;

  typedef struct packed {
    logic [63:0] r;
    status_t     st;
    logic        ext;
    logic [3:0]  tag;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NL-1:0]           lane_valid;
  logic [NL-1:0][63:0]     lane_result;
  status_t [NL-1:0]        lane_status;
  logic [NL-1:0]           lane_ext;
  logic [NL-1:0][3:0]      lane_tag;
  logic                    issue_valid, flush, out_ready;
  logic [2:0]              issue_lane;
  int                      sel;

  logic [NL-1:0] lv [2];
  logic          iv1;
  assign lv[0] = (sel == 0) ? lane_valid : '0;
  assign lv[1] = (sel == 1) ? lane_valid : '0;
  assign iv1   = issue_valid && (sel == 1);

  logic [NL-1:0] lrdy [2];
  logic          irdy [2], ov [2], oext [2], obusy [2];
  logic [63:0]   ores [2];
  status_t       ost [2];
  logic [3:0]    otag [2];
  logic [2:0]    olane [2];

  fpnew_opgroup_result_merger #(.NumLanes(NL), .Width(64), .FifoDepth(FD), .InOrder(1'b0),
                                .OrderDepth(OD), .TagType(logic [3:0])) u_rr (
    .clk_i(clk), .rst_ni(rst_n), .lane_valid_i(lv[0]), .lane_ready_o(lrdy[0]),
    .lane_result_i(lane_result), .lane_status_i(lane_status), .lane_ext_bit_i(lane_ext),
    .lane_tag_i(lane_tag), .issue_valid_i(1'b0), .issue_lane_i(issue_lane),
    .issue_ready_o(irdy[0]), .flush_i(flush), .out_valid_o(ov[0]), .out_ready_i(out_ready),
    .result_o(ores[0]), .status_o(ost[0]), .extension_bit_o(oext[0]), .tag_o(otag[0]),
    .out_lane_o(olane[0]), .busy_o(obusy[0]));

  fpnew_opgroup_result_merger #(.NumLanes(NL), .Width(64), .FifoDepth(FD), .InOrder(1'b1),
                                .OrderDepth(OD), .TagType(logic [3:0])) u_io (
    .clk_i(clk), .rst_ni(rst_n), .lane_valid_i(lv[1]), .lane_ready_o(lrdy[1]),
    .lane_result_i(lane_result), .lane_status_i(lane_status), .lane_ext_bit_i(lane_ext),
    .lane_tag_i(lane_tag), .issue_valid_i(iv1), .issue_lane_i(issue_lane),
    .issue_ready_o(irdy[1]), .flush_i(flush), .out_valid_o(ov[1]), .out_ready_i(out_ready),
    .result_o(ores[1]), .status_o(ost[1]), .extension_bit_o(oext[1]), .tag_o(otag[1]),
    .out_lane_o(olane[1]), .busy_o(obusy[1]));

  // Reference model: per-lane result queues, issue-order queue, RR pointer, held grant.
  ent_t mq [2][NL][$];
  int   oq [$];
  int   ptr [2];
  int   held [2];
  int   credit [NL];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string nm, input int m, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d @%0t: got %h expected %h", nm, m, $time, act, exp);
    end
  endtask

  task automatic model_clear(input int m);
    for (int l = 0; l < NL; l++) mq[m][l].delete();
    ptr[m]  = 0;
    held[m] = -1;
    if (m == 1) begin
      oq.delete();
      for (int l = 0; l < NL; l++) credit[l] = 0;
    end
  endtask

  task automatic step(input int m);
    bit ev, anyq, pop;
    int el, oqpre;
    int pre [NL];
    logic [NL-1:0] er;
    ent_t e;
    ev = 1'b0; anyq = 1'b0; el = 0; er = '0;
    for (int l = 0; l < NL; l++) begin
      pre[l] = mq[m][l].size();
      anyq   = anyq | (pre[l] > 0);
      er[l]  = (pre[l] < FD);
    end
    oqpre = oq.size();
    if (m == 0) begin
      if (held[0] >= 0) begin
        ev = 1'b1; el = held[0];
      end else begin
        for (int k = 0; k < NL; k++) begin
          int l = (ptr[0] + k) % NL;
          if (!ev && pre[l] > 0) begin ev = 1'b1; el = l; end
        end
      end
    end else if (oqpre > 0) begin
      el = oq[0];
      ev = (pre[el] > 0);
    end
    pop = ev && out_ready;
    chk("out_valid", m, 64'(ov[m]), 64'(ev));
    chk("busy", m, 64'(obusy[m]), 64'(anyq || (m == 1 && oqpre > 0)));
    chk("lane_ready", m, 64'(lrdy[m]), 64'(er));
    chk("issue_ready", m, 64'(irdy[m]), 64'((m == 0) || (oqpre < OD) || pop));
    if (ev) begin
      e = mq[m][el][0];
      chk("out_lane", m, 64'(olane[m]), 64'(el));
      chk("result", m, ores[m], e.r);
      chk("status", m, 64'(ost[m]), 64'(e.st));
      chk("ext_bit", m, 64'(oext[m]), 64'(e.ext));
      chk("tag", m, 64'(otag[m]), 64'(e.tag));
    end
    if (flush) begin
      model_clear(m);
    end else begin
      if (pop) begin
        void'(mq[m][el].pop_front());
        if (m == 0) ptr[0] = (el + 1) % NL;
        else void'(oq.pop_front());
        held[m] = -1;
      end else begin
        held[m] = (m == 0 && ev) ? el : -1;
      end
      for (int l = 0; l < NL; l++) begin
        if (lv[m][l] && pre[l] < FD) begin
          e.r = lane_result[l]; e.st = lane_status[l]; e.ext = lane_ext[l]; e.tag = lane_tag[l];
          mq[m][l].push_back(e);
          if (m == 1) credit[l]--;
        end
      end
      if (m == 1 && iv1 && (oqpre < OD || pop)) begin
        oq.push_back(int'(issue_lane));
        credit[issue_lane]++;
      end
    end
  endtask

  // Output monitor and input recorder, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      model_clear(0);
      model_clear(1);
    end else begin
      for (int m = 0; m < 2; m++) step(m);
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic idle();
    lane_valid = '0; issue_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic rand_data();
    for (int l = 0; l < NL; l++) begin
      lane_result[l] = {$urandom, $urandom};
      lane_status[l] = status_t'($urandom_range(0, 31));
      lane_ext[l]    = 1'($urandom_range(0, 1));
      lane_tag[l]    = 4'($urandom_range(0, 15));
    end
  endtask

  task automatic io_results();
    for (int l = 0; l < NL; l++) lane_valid[l] = (credit[l] > 0) && ($urandom_range(0, 1) == 1);
  endtask

  initial begin
    sel = 0; out_ready = 1'b1; issue_lane = 3'd0;
    idle(); rand_data();
    cyc(3); rst_n = 1'b1; cyc(2);

    // Three lanes complete together; retire order 0, 2, 4.
    rand_data(); lane_valid = 5'b10101; cyc(1); idle(); cyc(6);

    // Stall with lane 1 held valid.
    out_ready = 1'b0; lane_result[1] = 64'hDEAD_BEEF; lane_valid = 5'b00010; cyc(5);
    idle(); out_ready = 1'b1; cyc(4);

    // In-order: issue 3, 0, 3; lane 0 completes first.
    sel = 1; issue_valid = 1'b1;
    issue_lane = 3'd3; cyc(1); issue_lane = 3'd0; cyc(1); issue_lane = 3'd3; cyc(1);
    issue_valid = 1'b0; rand_data(); lane_valid = 5'b00001; cyc(1); idle(); cyc(3);
    rand_data(); lane_valid = 5'b01000; cyc(1); rand_data(); cyc(1); idle(); cyc(5);

    // Fill the order FIFO, then issue and retire in the same cycle.
    out_ready = 1'b0; issue_valid = 1'b1; issue_lane = 3'd0; cyc(9);
    issue_valid = 1'b0; rand_data(); lane_valid = 5'b00001; cyc(2); idle();
    out_ready = 1'b1; issue_valid = 1'b1; cyc(1); issue_valid = 1'b0; out_ready = 1'b0; cyc(2);
    out_ready = 1'b1;
    repeat (40) begin rand_data(); io_results(); cyc(1); end
    idle(); cyc(2);

    // Flush with three buffered entries and lane 2 presenting.
    sel = 0; out_ready = 1'b0; rand_data(); lane_valid = 5'b01011; cyc(1);
    lane_valid = 5'b00100; flush = 1'b1; cyc(1); idle(); cyc(3); out_ready = 1'b1; cyc(2);

    // Random round-robin traffic.
    repeat (300) begin
      rand_data(); lane_valid = NL'($urandom);
      out_ready = ($urandom_range(0, 3) != 0); flush = ($urandom_range(0, 59) == 0); cyc(1);
    end
    idle(); out_ready = 1'b1; cyc(10);

    // Random in-order traffic; results only for lanes with outstanding issues.
    sel = 1;
    repeat (400) begin
      rand_data(); issue_valid = ($urandom_range(0, 1) == 1); issue_lane = 3'($urandom_range(0, NL-1));
      io_results(); out_ready = ($urandom_range(0, 3) != 0); flush = ($urandom_range(0, 79) == 0);
      cyc(1);
    end
    idle(); out_ready = 1'b1;
    repeat (60) begin rand_data(); io_results(); cyc(1); end
    idle(); cyc(4);

    // Async reset in the middle of a stall, with the pointer away from zero.
    sel = 0; out_ready = 1'b1; rand_data(); lane_valid = 5'b00100; cyc(1); idle(); cyc(2);
    out_ready = 1'b0; rand_data(); lane_valid = 5'b10001; cyc(1); idle(); cyc(2);
    rst_n = 1'b0; #1;
    chk("async_rst_valid", 0, 64'(ov[0]), 64'd0);
    chk("async_rst_ready", 0, 64'(lrdy[0]), 64'h1F);
    chk("async_rst_busy", 0, 64'(obusy[0]), 64'd0);
    chk("async_rst_issue_ready", 1, 64'(irdy[1]), 64'd1);
    cyc(2); rst_n = 1'b1; cyc(1);
    out_ready = 1'b1; rand_data(); lane_valid = 5'b01010; cyc(1); idle(); cyc(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
